// File: rtl/sdram_init_chk.sv
// sdram_init_chk
//   Passive monitor for the SDRAM command bus during power-up initialisation.
//   It follows the sequence as the device sees it: a power-up wait,
//   precharge-all, tRP, N auto-refreshes each followed by tRFC, then a mode
//   register set followed by tMRD. It reports readiness, the latched mode
//   register and flags the first sequence or timing violation.
//
//   Optional feature macro: SDRAM_INIT_CHK_POSTINIT_EN
//     defined   : READY keeps checking tRP/tRFC after PRE/AREF and re-latches
//                 mode_reg on a legal MRS.
//     undefined : READY ignores the bus.
//
// Ports
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   cmd[3:0]       in   {cs_n,ras_n,cas_n,we_n}
//   bank_addr[1:0] in   bank address bus
//   addr[12:0]     in   address bus
//   dev_ready      out  initialisation complete and legal
//   mode_reg[12:0] out  addr latched at a legal MRS
//   cas_latency    out  mode_reg[6:4]
//   burst_len_code out  mode_reg[2:0]
//   aref_count     out  AREFs seen during init, saturating at 15
//   err_flag       out  sticky violation flag
//   err_code       out  first violation code (0 = none)
//
// Error codes: 1 command during power-up wait, 2 PRE without A10,
//   3 tRP/tRFC/tMRD gap too short, 4 unexpected command,
//   5 too few AREFs before MRS, 6 illegal MRS bank/reserved bits.
//
// Bus handshake: there is none; the monitor samples cmd/bank_addr/addr on
// every rising clk edge and never stalls the observed bus.
//
// The FSM state is held in the register 'state' for checker binding.
module sdram_init_chk #(
  parameter int T_PWR  = 20000,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 7,
  parameter int T_MRD  = 2,
  parameter int N_AREF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cmd,
  input  logic [1:0]  bank_addr,
  input  logic [12:0] addr,
  output logic        dev_ready,
  output logic [12:0] mode_reg,
  output logic [2:0]  cas_latency,
  output logic [2:0]  burst_len_code,
  output logic [3:0]  aref_count,
  output logic        err_flag,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    TRP      = 3'd1,
    TRFC     = 3'd2,
    TMRD     = 3'd3,
    READY    = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [15:0] T_PWR_C  = 16'(T_PWR);
  localparam logic [15:0] T_RP_C   = 16'(T_RP);
  localparam logic [15:0] T_RFC_C  = 16'(T_RFC);
  localparam logic [15:0] T_MRD_C  = 16'(T_MRD);
  localparam logic [3:0]  N_AREF_C = 4'(N_AREF);

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_EARLY  = 3'd1;
  localparam logic [2:0] E_PRE_A10 = 3'd2;
  localparam logic [2:0] E_TIMING = 3'd3;
  localparam logic [2:0] E_SEQ    = 3'd4;
  localparam logic [2:0] E_NAREF  = 3'd5;
  localparam logic [2:0] E_MRS    = 3'd6;

  state_t      state;
  logic [15:0] gap;        // NOP cycles since the last non-NOP (or reset release)

  logic       is_nop;
  logic       is_pre;
  logic       is_aref;
  logic       is_mrs;
  logic       mrs_legal;
  logic [2:0] viol;        // violation detected by the command at this edge

`ifdef SDRAM_INIT_CHK_POSTINIT_EN
  logic last_pre;          // most recent non-NOP was a PRE
  logic last_aref;         // most recent non-NOP was an AREF
`endif

  // Command decode. cs_n high deselects the device, which is a NOP too.
  always_comb begin
    is_nop    = cmd[3] | (cmd == 4'b0111);
    is_pre    = (cmd == 4'b0010);
    is_aref   = (cmd == 4'b0001);
    is_mrs    = (cmd == 4'b0000);
    mrs_legal = (bank_addr == 2'b00) && (addr[12:10] == 3'b000);
  end

  // Violation decode for the command sampled at this edge. Timing checks
  // take priority over sequence checks within each state.
  always_comb begin
    viol = E_NONE;
    case (state)
      PWR_WAIT: begin
        if (!is_nop) begin
          if (gap < T_PWR_C)             viol = E_EARLY;
          else if (is_pre && !addr[10])  viol = E_PRE_A10;
          else if (!is_pre)              viol = E_SEQ;
        end
      end
      TRP: begin
        if (!is_nop) begin
          if (gap < T_RP_C)              viol = E_TIMING;
          else if (!is_aref)             viol = E_SEQ;
        end
      end
      TRFC: begin
        if (!is_nop) begin
          if (gap < T_RFC_C)             viol = E_TIMING;
          else if (is_mrs) begin
            if (aref_count < N_AREF_C)   viol = E_NAREF;
            else if (!mrs_legal)         viol = E_MRS;
          end
          else if (!is_aref)             viol = E_SEQ;
        end
      end
      TMRD: begin
        if (!is_nop) begin
          if (gap < T_MRD_C)             viol = E_TIMING;
          else                           viol = E_SEQ;
        end
      end
      READY: begin
`ifdef SDRAM_INIT_CHK_POSTINIT_EN
        if (!is_nop) begin
          if ((last_pre && (gap < T_RP_C)) || (last_aref && (gap < T_RFC_C)))
            viol = E_TIMING;
          else if (is_mrs && !mrs_legal)
            viol = E_MRS;
        end
`endif
      end
      default: viol = E_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      gap        <= 16'd0;
      dev_ready  <= 1'b0;
      mode_reg   <= 13'd0;
      aref_count <= 4'd0;
      err_flag   <= 1'b0;
      err_code   <= E_NONE;
`ifdef SDRAM_INIT_CHK_POSTINIT_EN
      last_pre   <= 1'b0;
      last_aref  <= 1'b0;
`endif
    end else begin
      // Gap counter runs in every state; in PWR_WAIT this is simply the
      // number of cycles since reset release because any command leaves it.
      if (!is_nop)
        gap <= 16'd0;
      else if (gap != 16'hFFFF)
        gap <= gap + 16'd1;

`ifdef SDRAM_INIT_CHK_POSTINIT_EN
      if (!is_nop) begin
        last_pre  <= is_pre;
        last_aref <= is_aref;
      end
`endif

      if (viol != E_NONE) begin
        // ERROR is absorbing, so this branch only ever fires once per reset.
        state     <= ERROR;
        err_flag  <= 1'b1;
        err_code  <= viol;
        dev_ready <= 1'b0;
      end else begin
        case (state)
          PWR_WAIT: begin
            if (is_pre) state <= TRP;
          end
          TRP: begin
            if (is_aref) begin
              state <= TRFC;
              if (aref_count != 4'hF) aref_count <= aref_count + 4'd1;
            end
          end
          TRFC: begin
            if (is_aref) begin
              if (aref_count != 4'hF) aref_count <= aref_count + 4'd1;
            end else if (is_mrs) begin
              mode_reg <= addr;
              state    <= TMRD;
            end
          end
          TMRD: begin
            // No violation here means the bus is idle; dev_ready follows
            // one cycle after entering READY.
            if (gap >= T_MRD_C) state <= READY;
          end
          READY: begin
            dev_ready <= 1'b1;
`ifdef SDRAM_INIT_CHK_POSTINIT_EN
            if (is_mrs) mode_reg <= addr;
`endif
          end
          default: begin
            dev_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cas_latency    = mode_reg[6:4];
  assign burst_len_code = mode_reg[2:0];

endmodule

// File: tb/tb_sdram_init_chk.sv
// tb_sdram_init_chk
//   Directed bench for sdram_init_chk. The power-up wait is shortened to
//   T_PWR_TB cycles so every scenario can restart from reset; all other
//   timing parameters keep their default values.
module tb_sdram_init_chk;

  localparam int T_PWR_TB = 4000;

  localparam logic [3:0] C_NOP  = 4'b1111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MRS  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cmd = 4'b1111;
  logic [1:0]  bank_addr = 2'b00;
  logic [12:0] addr = 13'd0;
  logic        dev_ready;
  logic [12:0] mode_reg;
  logic [2:0]  cas_latency;
  logic [2:0]  burst_len_code;
  logic [3:0]  aref_count;
  logic        err_flag;
  logic [2:0]  err_code;

  int total = 0;
  int bad   = 0;

  sdram_init_chk #(.T_PWR(T_PWR_TB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd            (cmd),
    .bank_addr      (bank_addr),
    .addr           (addr),
    .dev_ready      (dev_ready),
    .mode_reg       (mode_reg),
    .cas_latency    (cas_latency),
    .burst_len_code (burst_len_code),
    .aref_count     (aref_count),
    .err_flag       (err_flag),
    .err_code       (err_code)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are
  // sampled 1 time unit after the edge that consumed them.
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    cmd = c;
    bank_addr = b;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 2'b00, 13'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step(C_NOP, 2'b00, 13'd0);
    rst_n = 1'b1;
  endtask

  task automatic power_up;
    nops(T_PWR_TB);
    step(C_PRE, 2'b00, 13'h1FFF);
  endtask

  // Scenarios
  task automatic test_reset;
    do_reset();
    total++;
    if ({dev_ready, mode_reg, aref_count, err_flag, err_code} !== 22'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b mr=%h ac=%0d ef=%b ec=%0d want all 0",
               dev_ready, mode_reg, aref_count, err_flag, err_code);
    end
  endtask

  task automatic test_nominal;
    do_reset();
    power_up();
    nops(3);
    for (int i = 0; i < 8; i++) begin
      step(C_AREF, 2'b00, 13'd0);
      nops(8);
    end
    step(C_MRS, 2'b00, 13'h037);
    nops(3);
    total++;
    if (dev_ready !== 1'b0) begin
      bad++;
      $display("FAIL nominal_ready_early: got %b want 0", dev_ready);
    end
    nops(1);
    total++;
    if ({dev_ready, err_flag, err_code} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL nominal_status: got rdy=%b ef=%b ec=%0d want rdy=1 ef=0 ec=0",
               dev_ready, err_flag, err_code);
    end
    total++;
    if ({cas_latency, burst_len_code} !== {3'd3, 3'd7}) begin
      bad++;
      $display("FAIL nominal_fields: got cl=%0d bl=%0d want cl=3 bl=7",
               cas_latency, burst_len_code);
    end
    total++;
    if ({mode_reg, aref_count} !== {13'h037, 4'd8}) begin
      bad++;
      $display("FAIL nominal_regs: got mr=%h ac=%0d want mr=037 ac=8", mode_reg, aref_count);
    end
  endtask

  // Continues from READY left by test_nominal.
  task automatic test_postinit;
    step(C_AREF, 2'b00, 13'd0);
    nops(2);
    step(C_AREF, 2'b00, 13'd0);
    total++;
`ifdef SDRAM_INIT_CHK_POSTINIT_EN
    if ({dev_ready, err_flag, err_code} !== {1'b0, 1'b1, 3'd3}) begin
      bad++;
      $display("FAIL postinit_aref: got rdy=%b ef=%b ec=%0d want rdy=0 ef=1 ec=3",
               dev_ready, err_flag, err_code);
    end
`else
    if ({dev_ready, err_flag, err_code} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL postinit_aref: got rdy=%b ef=%b ec=%0d want rdy=1 ef=0 ec=0",
               dev_ready, err_flag, err_code);
    end
`endif
  endtask

  task automatic test_early_pre;
    do_reset();
    nops(99);
    step(C_PRE, 2'b00, 13'h1FFF);
    total++;
    if ({dev_ready, err_flag, err_code} !== {1'b0, 1'b1, 3'd1}) begin
      bad++;
      $display("FAIL early_pre: got rdy=%b ef=%b ec=%0d want rdy=0 ef=1 ec=1",
               dev_ready, err_flag, err_code);
    end
    nops(50);
    total++;
    if ({dev_ready, err_flag, err_code} !== {1'b0, 1'b1, 3'd1}) begin
      bad++;
      $display("FAIL early_pre_hold: got rdy=%b ef=%b ec=%0d want rdy=0 ef=1 ec=1",
               dev_ready, err_flag, err_code);
    end
  endtask

  // One cycle short of the power-up wait.
  task automatic test_pwr_boundary;
    do_reset();
    nops(T_PWR_TB - 1);
    step(C_PRE, 2'b00, 13'h1FFF);
    total++;
    if (err_code !== 3'd1) begin
      bad++;
      $display("FAIL pwr_boundary: got ec=%0d want 1", err_code);
    end
  endtask

  task automatic test_short_trp;
    do_reset();
    power_up();
    nops(1);
    step(C_AREF, 2'b00, 13'd0);
    total++;
    if (err_code !== 3'd3) begin
      bad++;
      $display("FAIL short_trp: got ec=%0d want 3", err_code);
    end
    nops(3);
    step(C_AREF, 2'b00, 13'd0);
    nops(8);
    step(C_AREF, 2'b00, 13'd0);
    nops(8);
    step(C_MRS, 2'b00, 13'h037);
    nops(4);
    total++;
    if ({dev_ready, err_flag, err_code, mode_reg} !== {1'b0, 1'b1, 3'd3, 13'd0}) begin
      bad++;
      $display("FAIL short_trp_sticky: got rdy=%b ef=%b ec=%0d mr=%h want rdy=0 ef=1 ec=3 mr=0",
               dev_ready, err_flag, err_code, mode_reg);
    end
  endtask

  // tRP met exactly, then only one AREF before MRS.
  task automatic test_few_aref;
    do_reset();
    power_up();
    nops(2);
    step(C_AREF, 2'b00, 13'd0);
    nops(8);
    step(C_MRS, 2'b00, 13'h037);
    total++;
    if ({err_code, mode_reg, aref_count} !== {3'd5, 13'd0, 4'd1}) begin
      bad++;
      $display("FAIL few_aref: got ec=%0d mr=%h ac=%0d want ec=5 mr=0 ac=1",
               err_code, mode_reg, aref_count);
    end
  endtask

  task automatic test_short_trfc;
    do_reset();
    power_up();
    nops(2);
    step(C_AREF, 2'b00, 13'd0);
    nops(6);
    step(C_AREF, 2'b00, 13'd0);
    total++;
    if ({err_code, aref_count} !== {3'd3, 4'd1}) begin
      bad++;
      $display("FAIL short_trfc: got ec=%0d ac=%0d want ec=3 ac=1", err_code, aref_count);
    end
  endtask

  task automatic test_mrs_bank;
    do_reset();
    power_up();
    nops(3);
    for (int i = 0; i < 2; i++) begin
      step(C_AREF, 2'b00, 13'd0);
      nops(7);
    end
    step(C_MRS, 2'b01, 13'h037);
    total++;
    if ({err_code, mode_reg, aref_count} !== {3'd6, 13'd0, 4'd2}) begin
      bad++;
      $display("FAIL mrs_bank: got ec=%0d mr=%h ac=%0d want ec=6 mr=0 ac=2",
               err_code, mode_reg, aref_count);
    end
  endtask

  task automatic test_pre_a10;
    do_reset();
    nops(T_PWR_TB);
    step(C_PRE, 2'b00, 13'h0000);
    total++;
    if ({err_flag, err_code} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL pre_a10: got ef=%b ec=%0d want ef=1 ec=2", err_flag, err_code);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    power_up();
    nops(2);
    step(C_AREF, 2'b00, 13'd0);
    nops(3);
    total++;
    if ({aref_count, err_flag} !== {4'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_pre: got ac=%0d ef=%b want ac=1 ef=0", aref_count, err_flag);
    end
    rst_n = 1'b0;
    step(C_NOP, 2'b00, 13'd0);
    rst_n = 1'b1;
    total++;
    if ({dev_ready, mode_reg, aref_count, err_flag, err_code} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_clear: got rdy=%b mr=%h ac=%0d ef=%b ec=%0d want all 0",
               dev_ready, mode_reg, aref_count, err_flag, err_code);
    end
    nops(99);
    step(C_PRE, 2'b00, 13'h1FFF);
    total++;
    if (err_code !== 3'd1) begin
      bad++;
      $display("FAIL reset_mid_early: got ec=%0d want 1", err_code);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_nominal();
    test_postinit();
    test_early_pre();
    test_pwr_boundary();
    test_short_trp();
    test_few_aref();
    test_short_trfc();
    test_mrs_bank();
    test_pre_a10();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
